// File: rtl/vga_tile_scanout.sv
// vga_tile_scanout: 640x480@60 VGA scanout of a 20x15 byte tile buffer.
// Optional macro GRID_LINES_EN blanks the first row/column of every cell.
module vga_tile_scanout #(
  parameter int VIDEO_BASE = 212,
  parameter int COLS       = 20,
  parameter int ROWS       = 15,
  parameter int CELL_LOG2  = 5,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [8:0] vaddr,
  input  logic [7:0] vdata,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic [1:0] vga_r,
  output logic [1:0] vga_g,
  output logic [1:0] vga_b,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_LO  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_LO  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [8:0] BASE   = 9'(VIDEO_BASE);
  localparam logic [8:0] N_COLS = 9'(COLS);
  localparam logic [8:0] N_ROWS = 9'(ROWS);

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic       tick;
  } px_t;

  localparam px_t PX_RST = '{hs: 1'b1, vs: 1'b1, default: '0};

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_wrap;
  logic       v_wrap;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
      if (h_wrap) begin
        v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
      end
    end
  end

  logic [8:0] col;
  logic [8:0] row;
  logic [8:0] row_off;
  logic       active;
  logic       grid;
  logic       lit;

  assign col = 9'(h_cnt >> CELL_LOG2);
  assign row = 9'(v_cnt >> CELL_LOG2);

  // Stock 20-column layout uses shift-add; other widths multiply.
  generate
    if (COLS == 20) begin : g_x20
      assign row_off = (row << 4) + (row << 2);
    end else begin : g_xn
      assign row_off = row * N_COLS;
    end
  endgenerate

  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT)
               && (col < N_COLS) && (row < N_ROWS);

  assign vaddr = active ? BASE + row_off + col : BASE;

`ifdef GRID_LINES_EN
  localparam logic [9:0] CELL_MASK = 10'((1 << CELL_LOG2) - 1);
  assign grid = ((h_cnt & CELL_MASK) == '0)
             || ((v_cnt & CELL_MASK) == '0);
`else
  assign grid = 1'b0;
`endif

  assign lit = active && !grid;

  px_t px_d;
  px_t px_q;

  always_comb begin
    px_d      = PX_RST;
    px_d.hs   = !((h_cnt >= HS_LO) && (h_cnt <= HS_HI));
    px_d.vs   = !((v_cnt >= VS_LO) && (v_cnt <= VS_HI));
    px_d.tick = (h_cnt == '0) && (v_cnt == V_ACT);
    if (lit) begin
      px_d.r = vdata[5:4];
      px_d.g = vdata[3:2];
      px_d.b = vdata[1:0];
    end
  end

  // Sync and colour share one register so they stay pixel-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q <= PX_RST;
    end else begin
      px_q <= px_d;
    end
  end

  assign vga_hsync  = px_q.hs;
  assign vga_vsync  = px_q.vs;
  assign vga_r      = px_q.r;
  assign vga_g      = px_q.g;
  assign vga_b      = px_q.b;
  assign frame_tick = px_q.tick;

  logic unused_vdata;
  assign unused_vdata = ^vdata[7:6];

endmodule
